// File: rtl/stopwatch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl_pkg
//   Shared definitions for the stopwatch control stage: mode encodings used on
//   the mode output and inside the FSM, and the default debounce and prescaler
//   settings.
// -----------------------------------------------------------------------------
package stopwatch_ctrl_pkg;

  // Mode encoding as seen on the mode output. 2'b11 is never produced.
  typedef enum logic [1:0] {
    MODE_IDLE   = 2'b00,
    MODE_RUN    = 2'b01,
    MODE_PAUSED = 2'b10
  } mode_e;

  localparam int DEF_DEB_CYCLES = 4;   // stable cycles before a level is accepted
  localparam int DEF_TICK_DIV   = 10;  // clk cycles per count tick while running

endpackage : stopwatch_ctrl_pkg

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//   Two-flop synchroniser, debounce counter and press-edge detector for one
//   raw push button.
//
//   Ports
//     clk      in  system clock
//     reset    in  synchronous, active-high reset
//     i_btn    in  raw asynchronous button level (active-high)
//     o_press  out one-cycle pulse when a debounced 0->1 transition is accepted
//
//   The accepted level only flips after the synchronised level has differed
//   from it for DEB_CYCLES consecutive cycles. Releases are tracked but never
//   produce a pulse. The pulse is registered, so it appears one cycle after
//   the accepted level rises.
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEB_CYCLES = 4,
  parameter int DEB_W      = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_press
);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;    // accepted (debounced) level
  logic             r_level_d;  // accepted level one cycle ago
  logic             r_press;
  logic [DEB_W-1:0] r_cnt;

  // NOTE: every flop here, synchroniser included, is cleared by reset so a
  // button held across reset starts from a known "released" state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      // NOTE: non-blocking assignments make r_sync2 take the old r_sync1,
      // giving a true two-stage chain regardless of statement order.
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;

      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == DEB_LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + DEB_W'(1);
      end

      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d;
    end
  end

  assign o_press = r_press;

endmodule : btn_debounce

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//   Upstream control stage of the stopwatch counter chain: debounces the raw
//   buttons, runs the IDLE/RUN/PAUSED mode FSM and produces the prescaled
//   count-enable tick for the least-significant digit counter.
//
//   Ports
//     clk        in   system clock
//     reset      in   synchronous, active-high reset
//     btn_start  in   raw start/resume button
//     btn_stop   in   raw stop button
//     btn_clear  in   raw clear button
//     btn_lap    in   raw lap button            (STOPWATCH_LAP_EN only)
//     lap_hold   out  display-freeze level      (STOPWATCH_LAP_EN only)
//     run        out  1 only in RUN
//     stop_o     out  1 only in PAUSED
//     clear_o    out  one-cycle pulse returning the counters to zero
//     tick       out  one-cycle count enable, only while running
//     mode       out  00 IDLE, 01 RUN, 10 PAUSED
//
//   Build option: define STOPWATCH_LAP_EN to add the lap button and lap_hold.
//   Press priority within one cycle is clear > stop > start.
// -----------------------------------------------------------------------------
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int DEB_W      = 16,
  parameter int DIV_W      = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_clear,
`ifdef STOPWATCH_LAP_EN
  input  logic       btn_lap,
  output logic       lap_hold,
`endif
  output logic       run,
  output logic       stop_o,
  output logic       clear_o,
  output logic       tick,
  output logic [1:0] mode
);

  // Parameter range checks, resolved at elaboration.
  if (DEB_CYCLES < 1) begin : g_bad_deb_cycles
    $error("stopwatch_ctrl: DEB_CYCLES must be >= 1");
  end
  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("stopwatch_ctrl: TICK_DIV must be >= 2");
  end
  if (64'(DEB_CYCLES) >= (64'd1 << DEB_W)) begin : g_bad_deb_w
    $error("stopwatch_ctrl: DEB_W too narrow for DEB_CYCLES");
  end
  if (64'(TICK_DIV - 1) >= (64'd1 << DIV_W)) begin : g_bad_div_w
    $error("stopwatch_ctrl: DIV_W too narrow for TICK_DIV-1");
  end

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic             w_start_press;
  logic             w_stop_press;
  logic             w_clear_press;
  mode_e            r_state;
  mode_e            w_next;
  logic             w_clear_evt;
  logic             r_run;
  logic             r_stop;
  logic             r_clear;
  logic             r_tick;
  logic [DIV_W-1:0] r_div;
  logic             w_advance;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_start (
    .clk(clk), .reset(reset), .i_btn(btn_start), .o_press(w_start_press)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_stop (
    .clk(clk), .reset(reset), .i_btn(btn_stop), .o_press(w_stop_press)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_clear (
    .clk(clk), .reset(reset), .i_btn(btn_clear), .o_press(w_clear_press)
  );

  // Next-state logic. Stop is only meaningful in RUN, clear only outside RUN,
  // so checking clear before start gives the required clear > stop > start.
  // NOTE: both outputs get a default before the case so every path assigns
  // them and no latch is inferred.
  always_comb begin
    w_next      = r_state;
    w_clear_evt = 1'b0;
    case (r_state)
      MODE_IDLE: begin
        if (w_clear_press) begin
          w_clear_evt = 1'b1;
        end else if (w_start_press) begin
          w_next = MODE_RUN;
        end
      end
      MODE_RUN: begin
        if (w_stop_press) begin
          w_next = MODE_PAUSED;
        end
      end
      MODE_PAUSED: begin
        if (w_clear_press) begin
          w_next      = MODE_IDLE;
          w_clear_evt = 1'b1;
        end else if (w_start_press) begin
          w_next = MODE_RUN;
        end
      end
      default: w_next = MODE_IDLE;
    endcase
  end

  // The prescaler only advances on cycles that stay in RUN. Gating on both
  // the current and next state keeps tick from ever coinciding with run=0:
  // the edge that leaves RUN does not count, and neither does the edge that
  // enters it.
  assign w_advance = (r_state == MODE_RUN) && (w_next == MODE_RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= MODE_IDLE;
      r_run   <= 1'b0;
      r_stop  <= 1'b0;
      r_clear <= 1'b0;
    end else begin
      r_state <= w_next;
      r_run   <= (w_next == MODE_RUN);
      r_stop  <= (w_next == MODE_PAUSED);
      r_clear <= w_clear_evt;
    end
  end

  // Partial count is held across PAUSED so a resume neither loses nor
  // duplicates a tick; IDLE (which includes every clear) zeroes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else if (w_next == MODE_IDLE) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else if (w_advance) begin
      if (r_div == DIV_LAST) begin
        r_div  <= '0;
        r_tick <= 1'b1;
      end else begin
        r_div  <= r_div + DIV_W'(1);
        r_tick <= 1'b0;
      end
    end else begin
      r_tick <= 1'b0;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic w_lap_press;
  logic r_lap_hold;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_lap (
    .clk(clk), .reset(reset), .i_btn(btn_lap), .o_press(w_lap_press)
  );

  // Lap only toggles while running; any return to IDLE drops the freeze.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lap_hold <= 1'b0;
    end else if (w_next == MODE_IDLE) begin
      r_lap_hold <= 1'b0;
    end else if ((r_state == MODE_RUN) && w_lap_press) begin
      r_lap_hold <= ~r_lap_hold;
    end
  end

  assign lap_hold = r_lap_hold;
`endif

  assign run     = r_run;
  assign stop_o  = r_stop;
  assign clear_o = r_clear;
  assign tick    = r_tick;
  assign mode    = r_state;

endmodule : stopwatch_ctrl

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
//   Self-checking bench for stopwatch_ctrl (DEB_CYCLES=4, TICK_DIV=10).
//   A behavioural model keeps per-cycle histories of each raw button, derives
//   the debounced level from "last DEB samples after the synchroniser all
//   disagree with the accepted level", and tracks mode plus the total number
//   of running cycles; a tick is due whenever that total hits a multiple of
//   TICK_DIV. Directed scenarios are followed by randomized button activity.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

  localparam int DEB  = 4;
  localparam int DIV  = 10;
  localparam int NB   = 4;      // start, stop, clear, lap
  localparam int MAXC = 8192;   // history depth (indexed modulo)

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_PAUSED = 2;

  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_stop  = 1'b0;
  logic       btn_clear = 1'b0;
  logic       btn_lap   = 1'b0;
  logic       run;
  logic       stop_o;
  logic       clear_o;
  logic       tick;
  logic [1:0] mode;
`ifdef STOPWATCH_LAP_EN
  logic       lap_hold;
`endif

  stopwatch_ctrl #(
    .DEB_CYCLES(DEB), .TICK_DIV(DIV), .DEB_W(16), .DIV_W(24)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_start(btn_start),
    .btn_stop (btn_stop),
    .btn_clear(btn_clear),
`ifdef STOPWATCH_LAP_EN
    .btn_lap  (btn_lap),
    .lap_hold (lap_hold),
`endif
    .run      (run),
    .stop_o   (stop_o),
    .clear_o  (clear_o),
    .tick     (tick),
    .mode     (mode)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model state.
  bit b_hist[NB][MAXC];   // raw sample per edge (0 during reset)
  bit a_hist[NB][MAXC];   // accepted level after each edge
  int m_mode  = M_IDLE;
  bit m_clear = 1'b0;
  bit m_tick  = 1'b0;
  bit m_lap   = 1'b0;
  int m_runs  = 0;        // running cycles since last return to IDLE

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    n_tests++;
    if (got !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit get_b(input int i, input int n);
    return (n < 0) ? 1'b0 : b_hist[i][n % MAXC];
  endfunction

  function automatic bit get_a(input int i, input int n);
    return (n < 0) ? 1'b0 : a_hist[i][n % MAXC];
  endfunction

  task automatic model_update();
    bit raw[NB];
    bit pr[NB];
    bit prev;
    bit flip;
    int prev_mode;
    raw[0] = btn_start;
    raw[1] = btn_stop;
    raw[2] = btn_clear;
    raw[3] = btn_lap;
    for (int i = 0; i < NB; i++) b_hist[i][cyc % MAXC] = reset ? 1'b0 : raw[i];
    if (reset) begin
      for (int i = 0; i < NB; i++) a_hist[i][cyc % MAXC] = 1'b0;
      m_mode  = M_IDLE;
      m_clear = 1'b0;
      m_tick  = 1'b0;
      m_lap   = 1'b0;
      m_runs  = 0;
      return;
    end
    for (int i = 0; i < NB; i++) begin
      prev = get_a(i, cyc - 1);
      flip = 1'b1;
      for (int k = 0; k < DEB; k++) if (get_b(i, cyc - 2 - k) == prev) flip = 1'b0;
      a_hist[i][cyc % MAXC] = flip ? !prev : prev;
      // Press reaches the FSM two edges after the accepted level rises.
      pr[i] = get_a(i, cyc - 2) && !get_a(i, cyc - 3);
    end
    prev_mode = m_mode;
    m_clear   = 1'b0;
    if (m_mode == M_IDLE) begin
      if (pr[2]) m_clear = 1'b1;
      else if (pr[0]) m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (pr[1]) m_mode = M_PAUSED;
    end else begin
      if (pr[2]) begin
        m_mode  = M_IDLE;
        m_clear = 1'b1;
      end else if (pr[0]) begin
        m_mode = M_RUN;
      end
    end
    m_tick = 1'b0;
    if (prev_mode == M_RUN && m_mode == M_RUN) begin
      m_runs++;
      m_tick = (m_runs % DIV) == 0;
    end
    if (m_mode == M_IDLE) begin
      m_runs = 0;
      m_lap  = 1'b0;
    end else if (prev_mode == M_RUN && pr[3]) begin
      m_lap = !m_lap;
    end
  endtask

  // One clock: model follows the edge, DUT is sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check("mode", mode, m_mode);
    check("run", run, int'(m_mode == M_RUN));
    check("stop_o", stop_o, int'(m_mode == M_PAUSED));
    check("clear_o", clear_o, int'(m_clear));
    check("tick", tick, int'(m_tick));
`ifdef STOPWATCH_LAP_EN
    check("lap_hold", lap_hold, int'(m_lap));
`endif
    cyc++;
  endtask

  // which: 0 run, 1 stop_o, 2 tick, 3 clear_o. at = cyc when seen, else -1.
  task automatic wait_for(input int which, input int max_cyc, output int at);
    logic s;
    at = -1;
    for (int i = 0; i < max_cyc; i++) begin
      step();
      case (which)
        0:       s = run;
        1:       s = stop_o;
        2:       s = tick;
        default: s = clear_o;
      endcase
      if (s === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic hold_btn(input int which, input int n);
    case (which)
      0: btn_start = 1'b1;
      1: btn_stop  = 1'b1;
      2: btn_clear = 1'b1;
      default: btn_lap = 1'b1;
    endcase
    for (int i = 0; i < n; i++) step();
    case (which)
      0: btn_start = 1'b0;
      1: btn_stop  = 1'b0;
      2: btn_clear = 1'b0;
      default: btn_lap = 1'b0;
    endcase
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t0, lat, t1, t2, cnt, cnt2, saved_c, tr, tt, dur;

    // 1. Reset, then idle with no activity.
    for (int i = 0; i < 3; i++) step();
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (tick === 1'b1) cnt++;
    end
    check("idle_mode", mode, M_IDLE);
    check("idle_ticks", cnt, 0);

    // 2. Start: latency from raw rise, then tick spacing.
    btn_start = 1'b1;
    t0  = cyc;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (lat < 0 && run === 1'b1) lat = cyc - t0;
    end
    btn_start = 1'b0;
    check("start_latency", lat, 8);
    wait_for(2, 20, t1);
    wait_for(2, 20, t2);
    check("tick_spacing", (t1 >= 0 && t2 >= 0) ? t2 - t1 : -1, DIV);

    // 3. Bouncing stop is rejected; a clean hold pauses.
    for (int i = 0; i < 12; i++) begin
      btn_stop = ((i / 2) % 2) == 0;
      step();
    end
    btn_stop = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("bounce_mode", mode, M_RUN);
    hold_btn(1, 6);
    step();
    step();
    check("pause_mode", mode, M_PAUSED);
    check("pause_stop_o", stop_o, 1);

    // 4. Partial prescaler count survives a pause.
    hold_btn(0, 6);
    wait_for(0, 10, tr);
    check("resume_seen", int'(tr >= 0), 1);
    wait_for(2, 20, tt);
    check("tick_after_resume", int'(tt >= 0), 1);
    for (int i = 0; i < 16; i++) step();
    hold_btn(1, 6);
    wait_for(1, 10, t1);
    check("second_pause", int'(t1 >= 0), 1);
    saved_c = m_runs % DIV;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (tick === 1'b1) cnt++;
    end
    check("paused_ticks", cnt, 0);
    hold_btn(0, 6);
    wait_for(0, 10, tr);
    wait_for(2, 20, tt);
    check("resume_gap", (tr >= 0 && tt >= 0) ? tt - tr : -1, DIV - saved_c);

    // 5. Clear ignored in RUN; clear beats start in PAUSED.
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      btn_clear = (i < 6);
      step();
      if (clear_o === 1'b1) cnt++;
    end
    check("run_clear_ignored", cnt, 0);
    check("run_kept", run, 1);
    hold_btn(1, 6);
    wait_for(1, 10, t1);
    check("pause_before_clear", mode, M_PAUSED);
    btn_clear = 1'b1;
    btn_start = 1'b1;
    cnt  = 0;
    cnt2 = 0;
    for (int i = 0; i < 14; i++) begin
      if (i == 6) begin
        btn_clear = 1'b0;
        btn_start = 1'b0;
      end
      step();
      if (clear_o === 1'b1) cnt++;
      if (run === 1'b1) cnt2++;
    end
    check("clear_pulses", cnt, 1);
    check("clear_no_run", cnt2, 0);
    check("clear_mode", mode, M_IDLE);

    // 6. Reset mid-RUN with start held.
    btn_start = 1'b1;
    wait_for(0, 12, tr);
    check("run_before_reset", int'(tr >= 0), 1);
`ifdef STOPWATCH_LAP_EN
    hold_btn(3, 6);
    step();
    step();
    check("lap_toggle", lap_hold, 1);
`endif
    for (int i = 0; i < 5; i++) step();
    reset = 1'b1;
    step();
    check("reset_mode", mode, M_IDLE);
    check("reset_tick", tick, 0);
    check("reset_run", run, 0);
`ifdef STOPWATCH_LAP_EN
    check("reset_lap", lap_hold, 0);
`endif
    step();
    step();
    reset     = 1'b0;
    btn_start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (run === 1'b1) cnt++;
    end
    check("no_run_without_press", cnt, 0);
    hold_btn(0, 6);
    wait_for(0, 10, tr);
    check("fresh_press_runs", int'(tr >= 0), 1);

    // 7. Randomized button activity with occasional resets.
    for (int seg = 0; seg < 300; seg++) begin
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step();
        reset = 1'b0;
      end
      btn_start = ($urandom_range(0, 3) == 0);
      btn_stop  = ($urandom_range(0, 4) == 0);
      btn_clear = ($urandom_range(0, 7) == 0);
      btn_lap   = ($urandom_range(0, 3) == 0);
      dur = int'($urandom_range(1, 12));
      for (int i = 0; i < dur; i++) step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_stopwatch_ctrl
